cache_arbiter: RTL

Shares the single 64-bit burst physical-memory port between the instruction cache and the data cache of the pipelined RV32I core. Line-level cache requests are serialised into 4-beat bursts, and burst data is reassembled into full lines. The block sits between the two caches and the memory model. Each miss is served by one transaction at a time, from grant through response.

---
 rtl/cache_arbiter_pkg.sv | 23 ++
 rtl/cache_arbiter_line_buffer.sv | 38 +++
 rtl/cache_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types and constants for the cache/memory burst arbiter.
package arb_types;

  localparam int LINE_W_DEF = 256;
  localparam int BEAT_W_DEF = 64;
  localparam int ADDR_W_DEF = 32;
  localparam int BEATS      = LINE_W_DEF / BEAT_W_DEF;

  localparam logic [1:0] LAST_BEAT = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    RESP     = 2'd3
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } arb_src_t;

endpackage

// File: rtl/cache_arbiter_line_buffer.sv
// One-line staging register: parallel load for writebacks, beat-indexed
// write from memory read data, beat-indexed read mux toward memory.
module arb_line_buffer #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int IDX_W  = $clog2(LINE_W / BEAT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [LINE_W-1:0] load_data_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_beat_i,
  input  logic [BEAT_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_beat_i,
  output logic [LINE_W-1:0] line_o,
  output logic [BEAT_W-1:0] rd_data_o
);

  localparam int NBEATS = LINE_W / BEAT_W;

  logic [NBEATS-1:0][BEAT_W-1:0] line_q;

  // Line storage: parallel load has priority over single-beat writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (load_i) begin
      line_q <= load_data_i;
    end else if (wr_en_i) begin
      line_q[wr_beat_i] <= wr_data_i;
    end
  end

  assign line_o    = line_q;
  assign rd_data_o = line_q[rd_beat_i];

endmodule

// File: rtl/cache_arbiter.sv
// Serialises I-cache and D-cache line requests onto one 4-beat burst port.
// ARB_ROUND_ROBIN_EN selects alternating conflict arbitration; otherwise D wins.
module cache_arbiter
  import arb_types::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int OFFSET_W = $clog2(LINE_W / 8);

  arb_state_t        state_q, state_d;
  arb_src_t          src_q, src_d;
  arb_src_t          winner_s;
  arb_src_t          conflict_winner_s;
  logic [1:0]        beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] sel_addr_s;
  logic              mem_read_q, mem_write_q;
  logic              i_resp_q, d_resp_q;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_req_s, d_req_s;
  logic              grant_s, buf_load_s, beat_wr_s, last_beat_s;
  logic [LINE_W-1:0] buf_line_s, rd_line_s;
  logic [BEAT_W-1:0] buf_beat_s;

  assign i_req_s = i_read;
  assign d_req_s = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  arb_src_t last_grant_q;

  // Remember the most recent winner so conflicts alternate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= DCACHE;
    end else if (grant_s) begin
      last_grant_q <= winner_s;
    end
  end

  assign conflict_winner_s = (last_grant_q == DCACHE) ? ICACHE : DCACHE;
`else
  assign conflict_winner_s = DCACHE;
`endif

  // Pick the requester to serve when the arbiter is idle.
  always_comb begin
    winner_s = DCACHE;
    if (i_req_s && d_req_s) begin
      winner_s = conflict_winner_s;
    end else if (i_req_s) begin
      winner_s = ICACHE;
    end else begin
      winner_s = DCACHE;
    end
  end

  assign sel_addr_s = (winner_s == ICACHE) ? i_address : d_address;

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    beat_cnt_d  = beat_cnt_q;
    addr_d      = addr_q;
    grant_s     = 1'b0;
    buf_load_s  = 1'b0;
    beat_wr_s   = 1'b0;
    last_beat_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_s || d_req_s) begin
          grant_s    = 1'b1;
          src_d      = winner_s;
          beat_cnt_d = 2'd0;
          addr_d     = {sel_addr_s[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          // A simultaneous d_read and d_write is served as a writeback.
          if ((winner_s == DCACHE) && d_write) begin
            state_d    = WR_BURST;
            buf_load_s = 1'b1;
          end else begin
            state_d = RD_BURST;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_BURST: begin
        if (mem_resp) begin
          beat_wr_s  = 1'b1;
          beat_cnt_d = beat_cnt_q + 2'd1;
          if (beat_cnt_q == LAST_BEAT) begin
            last_beat_s = 1'b1;
            state_d     = RESP;
          end else begin
            state_d = RD_BURST;
          end
        end else begin
          state_d = RD_BURST;
        end
      end
      WR_BURST: begin
        if (mem_resp) begin
          beat_cnt_d = beat_cnt_q + 2'd1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = RESP;
          end else begin
            state_d = WR_BURST;
          end
        end else begin
          state_d = WR_BURST;
        end
      end
      RESP: begin
        state_d    = IDLE;
        beat_cnt_d = 2'd0;
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = 2'd0;
      end
    endcase
  end

  // State, transaction context and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= DCACHE;
      beat_cnt_q  <= 2'd0;
      addr_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      beat_cnt_q  <= beat_cnt_d;
      addr_q      <= addr_d;
      mem_read_q  <= (state_d == RD_BURST);
      mem_write_q <= (state_d == WR_BURST);
      i_resp_q    <= (state_d == RESP) && (src_d == ICACHE);
      d_resp_q    <= (state_d == RESP) && (src_d == DCACHE);
      if (last_beat_s && (src_q == ICACHE)) begin
        i_rdata_q <= rd_line_s;
      end
      if (last_beat_s && (src_q == DCACHE)) begin
        d_rdata_q <= rd_line_s;
      end
    end
  end

  arb_line_buffer #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .IDX_W  (2)
  ) u_line_buffer (
    .clk         (clk),
    .rst         (rst),
    .load_i      (buf_load_s),
    .load_data_i (d_wdata),
    .wr_en_i     (beat_wr_s),
    .wr_beat_i   (beat_cnt_q),
    .wr_data_i   (mem_rdata),
    .rd_beat_i   (beat_cnt_q),
    .line_o      (buf_line_s),
    .rd_data_o   (buf_beat_s)
  );

  // The last beat is merged on the fly so the response line is complete.
  assign rd_line_s = {mem_rdata, buf_line_s[LINE_W-BEAT_W-1:0]};

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = addr_q;
  assign mem_wdata   = mem_write_q ? buf_beat_s : {BEAT_W{1'b0}};
  assign i_resp      = i_resp_q;
  assign d_resp      = d_resp_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;

endmodule
